mult4_acc_stage: RTL and testbench



---
 rtl/mult4_acc_stage.sv | 96 +++++++++
 tb/tb_mult4_acc_stage.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mult4_acc_stage.sv
// Operand staging and dot-product accumulator around an external 4x4 multiplier.
// Pairs are registered onto mul_x/mul_y, and the returned products are summed per in_last-terminated group.
module mult4_acc_stage #(
    parameter int ACC_W = 16,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       in_x,
    input  logic [3:0]       in_y,
    input  logic             in_last,
    output logic [3:0]       mul_x,
    output logic [3:0]       mul_y,
    input  logic [7:0]       mul_p,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [ACC_W-1:0] out_acc,
    output logic [CNT_W-1:0] out_cnt,
    output logic             out_ovf
);

    logic             hold;
    logic             fire;
    logic             v1;
    logic             last1;
    logic [ACC_W-1:0] acc;
    logic [CNT_W-1:0] cnt;
    logic             ovf;
    logic [ACC_W:0]   sum_ext;
    logic [ACC_W-1:0] sum;
    logic             wrap;
    logic [CNT_W-1:0] cnt_n;
    logic             ovf_n;

    // A result that is waiting for the consumer freezes both stages.
    assign hold     = out_valid & ~out_ready;
    assign in_ready = ~hold;
    assign fire     = v1 & ~hold;

    assign sum_ext = {1'b0, acc} + {{(ACC_W - 7){1'b0}}, mul_p};
    assign sum     = sum_ext[ACC_W-1:0];
    assign wrap    = sum_ext[ACC_W];
    assign cnt_n   = (&cnt) ? cnt : cnt + CNT_W'(1);
    assign ovf_n   = ovf | wrap;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v1    <= 1'b0;
            last1 <= 1'b0;
            mul_x <= '0;
            mul_y <= '0;
        end else if (!hold) begin
            v1 <= in_valid;
            if (in_valid) begin
                mul_x <= in_x;
                mul_y <= in_y;
                last1 <= in_last;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc       <= '0;
            cnt       <= '0;
            ovf       <= 1'b0;
            out_acc   <= '0;
            out_cnt   <= '0;
            out_ovf   <= 1'b0;
            out_valid <= 1'b0;
        end else begin
            if (out_valid && out_ready) begin
                out_valid <= 1'b0;
            end
            // A freshly loaded result overrides the consume-clear above.
            if (fire) begin
                if (last1) begin
                    out_acc   <= sum;
                    out_cnt   <= cnt_n;
                    out_ovf   <= ovf_n;
                    out_valid <= 1'b1;
                    acc       <= '0;
                    cnt       <= '0;
                    ovf       <= 1'b0;
                end else begin
                    acc <= sum;
                    cnt <= cnt_n;
                    ovf <= ovf_n;
                end
            end
        end
    end

endmodule

// File: tb/tb_mult4_acc_stage.sv
// Scoreboard bench: a default-width instance and an ACC_W=8/CNT_W=2 instance share one stimulus stream.
module tb_mult4_acc_stage;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       in_valid = 1'b0;
    logic [3:0] in_x = '0;
    logic [3:0] in_y = '0;
    logic       in_last = 1'b0;
    logic       out_ready = 1'b1;

    logic        a_in_ready, a_out_valid, a_out_ovf;
    logic [3:0]  a_mul_x, a_mul_y;
    logic [7:0]  a_mul_p;
    logic [15:0] a_out_acc;
    logic [7:0]  a_out_cnt;

    logic        b_in_ready, b_out_valid, b_out_ovf;
    logic [3:0]  b_mul_x, b_mul_y;
    logic [7:0]  b_mul_p;
    logic [7:0]  b_out_acc;
    logic [1:0]  b_out_cnt;

    always #5 clk = ~clk;

    assign a_mul_p = {4'b0, a_mul_x} * {4'b0, a_mul_y};
    assign b_mul_p = {4'b0, b_mul_x} * {4'b0, b_mul_y};

    mult4_acc_stage #(.ACC_W(16), .CNT_W(8)) dut_a (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(a_in_ready),
        .in_x(in_x), .in_y(in_y), .in_last(in_last),
        .mul_x(a_mul_x), .mul_y(a_mul_y), .mul_p(a_mul_p),
        .out_valid(a_out_valid), .out_ready(out_ready),
        .out_acc(a_out_acc), .out_cnt(a_out_cnt), .out_ovf(a_out_ovf)
    );

    mult4_acc_stage #(.ACC_W(8), .CNT_W(2)) dut_b (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(b_in_ready),
        .in_x(in_x), .in_y(in_y), .in_last(in_last),
        .mul_x(b_mul_x), .mul_y(b_mul_y), .mul_p(b_mul_p),
        .out_valid(b_out_valid), .out_ready(out_ready),
        .out_acc(b_out_acc), .out_cnt(b_out_cnt), .out_ovf(b_out_ovf)
    );

    typedef struct {
        int unsigned acc16;
        int unsigned cnt8;
        bit          ovf16;
        int unsigned acc8;
        int unsigned cnt2;
        bit          ovf8;
        int          acc_cyc;
        bit          lat;
    } result_t;

    result_t q[$];

    int n_chk  = 0;
    int n_pass = 0;
    int cyc    = 0;

    int unsigned m_acc16 = 0, m_cnt8 = 0, m_acc8 = 0, m_cnt2 = 0;
    bit          m_ovf16 = 0, m_ovf8 = 0;

    always @(posedge clk) cyc = cyc + 1;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s got=%0d exp=%0d (t=%0t)", tag, got, exp, $time);
    endtask

    task automatic model_clear();
        m_acc16 = 0; m_cnt8 = 0; m_ovf16 = 0;
        m_acc8  = 0; m_cnt2 = 0; m_ovf8  = 0;
    endtask

    // Called at a negedge; returns at the negedge after the pair was accepted, in_valid still high.
    task automatic send(input int x, input int y, input bit last, input bit lat);
        int  waited = 0;
        bit  done = 0;
        int unsigned p;
        result_t e;
        in_valid = 1'b1;
        in_x     = 4'(x);
        in_y     = 4'(y);
        in_last  = last;
        while (!done) begin
            #4;
            if (a_in_ready) begin
                p = x * y;
                m_acc16 = m_acc16 + p;
                if (m_acc16 > 65535) begin m_acc16 -= 65536; m_ovf16 = 1; end
                m_acc8 = m_acc8 + p;
                if (m_acc8 > 255) begin m_acc8 -= 256; m_ovf8 = 1; end
                m_cnt8 = (m_cnt8 == 255) ? 255 : m_cnt8 + 1;
                m_cnt2 = (m_cnt2 == 3) ? 3 : m_cnt2 + 1;
                if (last) begin
                    e = '{m_acc16, m_cnt8, m_ovf16, m_acc8, m_cnt2, m_ovf8, cyc, lat};
                    q.push_back(e);
                    model_clear();
                end
                done = 1;
            end else if (++waited > 200) begin
                chk("accept_timeout", 32'd0, 32'd1);
                done = 1;
            end
            @(negedge clk);
        end
    endtask

    task automatic idle(input int n);
        in_valid = 1'b0;
        in_last  = 1'b0;
        repeat (n) @(negedge clk);
    endtask

    bit prev_valid = 0, prev_cons = 0;

    always begin
        result_t e;
        @(negedge clk);
        #4;
        if (!rst_n) begin
            prev_valid = 0;
            prev_cons  = 0;
        end else begin
            if (a_out_valid || b_out_valid) chk("valid_match", b_out_valid, a_out_valid);
            if (a_out_valid) begin
                if (q.size() == 0) begin
                    chk("spurious_valid", 32'd1, 32'd0);
                end else begin
                    e = q[0];
                    if ((!prev_valid || prev_cons) && e.lat)
                        chk("latency", 32'(cyc - e.acc_cyc), 32'd2);
                    if (!out_ready) begin
                        chk("hold_acc_a", a_out_acc, e.acc16);
                        chk("hold_acc_b", b_out_acc, e.acc8);
                    end else begin
                        chk("acc_a", a_out_acc, e.acc16);
                        chk("cnt_a", a_out_cnt, e.cnt8);
                        chk("ovf_a", a_out_ovf, e.ovf16);
                        chk("acc_b", b_out_acc, e.acc8);
                        chk("cnt_b", b_out_cnt, e.cnt2);
                        chk("ovf_b", b_out_ovf, e.ovf8);
                        void'(q.pop_front());
                    end
                end
            end
            prev_valid = a_out_valid;
            prev_cons  = a_out_valid && out_ready;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired at t=%0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (2) @(negedge clk);
        #4;
        chk("rst_in_ready", a_in_ready, 1'b1);
        chk("rst_mul_x", a_mul_x, 4'd0);
        chk("rst_mul_y", a_mul_y, 4'd0);
        chk("rst_out_valid", a_out_valid, 1'b0);
        chk("rst_out_acc", a_out_acc, 16'd0);
        chk("rst_out_cnt", a_out_cnt, 8'd0);
        chk("rst_out_ovf", a_out_ovf, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // basic group: 15 + 225 + 14 = 254
        send(3, 5, 0, 1); send(15, 15, 0, 1); send(7, 2, 1, 1);
        idle(4);

        // single-pair groups back to back
        send(0, 9, 1, 1); send(4, 4, 1, 1);
        idle(4);

        // backpressure: 254 held while (1,1) and (2,2) are offered
        send(3, 5, 0, 1); send(15, 15, 0, 1); send(7, 2, 1, 1);
        out_ready = 1'b0;
        fork
            begin
                send(1, 1, 1, 0);
                send(2, 2, 1, 0);
                idle(1);
            end
            begin
                @(negedge clk);
                repeat (3) begin
                    #4;
                    chk("stall_in_ready", a_in_ready, 1'b0);
                    chk("stall_out_acc", a_out_acc, 16'd254);
                    @(negedge clk);
                end
                out_ready = 1'b1;
            end
        join
        idle(5);

        // 450 wraps the 8-bit instance to 194; next group starts clean
        send(15, 15, 0, 1); send(15, 15, 1, 1); send(1, 1, 1, 1);
        idle(4);

        // five products saturate the 2-bit count
        for (int i = 0; i < 5; i++) send(1, 1, (i == 4), 1);
        idle(4);

        // reset mid-group discards the partial sum
        send(15, 15, 0, 1); send(15, 15, 0, 1);
        idle(0);
        #2;
        rst_n = 1'b0;
        #1;
        chk("midrst_in_ready", a_in_ready, 1'b1);
        chk("midrst_mul_x", a_mul_x, 4'd0);
        chk("midrst_mul_y", b_mul_y, 4'd0);
        chk("midrst_out_valid", a_out_valid, 1'b0);
        chk("midrst_out_acc", a_out_acc, 16'd0);
        chk("midrst_out_cnt", b_out_cnt, 2'd0);
        chk("midrst_out_ovf", b_out_ovf, 1'b0);
        model_clear();
        @(negedge clk);
        #2;
        rst_n = 1'b1;
        @(negedge clk);
        send(2, 3, 1, 1);
        idle(5);

        chk("queue_empty", q.size(), 32'd0);
        chk("final_idle", a_out_valid, 1'b0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
